// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory/data bus: registered one-hot grant,
// lock-protected multi-phase ownership, hold-timeout preemption and a one-cycle turnaround.
module mem_bus_arbiter #(
  parameter int REQ_COUNT  = 4,
  parameter int MAX_HOLD   = 8,
  parameter int IDX_WIDTH  = $clog2(REQ_COUNT),
  parameter int HOLD_WIDTH = $clog2(MAX_HOLD)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [REQ_COUNT-1:0] req,
  input  logic [REQ_COUNT-1:0] lock,
  output logic [REQ_COUNT-1:0] gnt,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 busy,
  output logic                 preempt,
  output logic [1:0]           dbg_state
);

  // Handshake: a master raises req and holds it (level) until done; it owns the
  // bus while its gnt bit is high, and ends ownership by dropping req.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [REQ_COUNT-1:0]   gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic [IDX_WIDTH-1:0]   rr_q, rr_d;
  logic                   preempt_q, preempt_d;

  logic                   win_found;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic [IDX_WIDTH-1:0]   cand_idx;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   others_req;
  logic                   hold_sat;

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      cand_idx = IDX_WIDTH'((int'(rr_q) + i) % REQ_COUNT);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign owner_req  = |(req & gnt_q);
  assign owner_lock = |(lock & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign hold_sat   = (hold_q == HOLD_WIDTH'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    rr_d      = rr_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (win_found) begin
          state_d          = GRANT;
          gnt_d[win_idx]   = 1'b1;
          idx_d            = win_idx;
          hold_d           = '0;
          rr_d             = IDX_WIDTH'((int'(win_idx) + 1) % REQ_COUNT);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (hold_sat && others_req && !owner_lock) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          preempt_d = 1'b1;
        end else if (!hold_sat) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      rr_q      <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      rr_q      <= rr_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign busy      = (state_q == GRANT);
  assign preempt   = preempt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Round-robin arbiter for the single shared memory/data bus of the machine. It sits between the ControlUnit-driven CPU datapath and the other bus masters (I/O, loader, debug port). It grants the bus to one requester at a time through a registered one-hot grant. Grants can be held across multi-phase instructions with a lock, and hogging is bounded by a hold timeout.

Parameters:
REQ_COUNT, 4, number of bus masters; legal range is 2 or more.
MAX_HOLD, 8, maximum consecutive grant cycles while another master waits; legal range is 2 or more.
IDX_WIDTH, $clog2(REQ_COUNT), width of gnt_idx (derived).
HOLD_WIDTH, $clog2(MAX_HOLD), width of the hold counter (derived).

Ports:
CLK  input  1  system clock; all state changes on posedge.
RST_N  input  1  asynchronous active-low reset.
req  input  REQ_COUNT  per-master bus request; level, held until done.
lock  input  REQ_COUNT  per-master lock; suppresses timeout preemption; ignored unless that master owns the bus.
gnt  output  REQ_COUNT  registered one-hot grant; all zero when no owner.
gnt_idx  output  IDX_WIDTH  index of the current owner; valid only while busy=1.
busy  output  1  high while the bus is granted (state GRANT).
preempt  output  1  one-cycle pulse in the first cycle after a timeout-forced release.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE, gnt=0, gnt_idx=0, busy=0, preempt=0.
  - hold_cnt=0, rr_ptr=0, so master 0 has highest priority.
- Winner selection: the first master with req set, scanning from rr_ptr upward and wrapping modulo REQ_COUNT.
- State IDLE:
  - No req: stay IDLE.
  - Any req: at the edge, load gnt=onehot(winner), gnt_idx=winner, hold_cnt=0, rr_ptr=(winner+1) mod REQ_COUNT; go to GRANT.
  - Latency from a sampled req to gnt is 1 cycle.
- State GRANT: evaluate on each edge with owner o. Priority order:
  1. req[o]=0: go to RELEASE; gnt=0 after the edge; preempt=0.
  2. hold_cnt==MAX_HOLD-1, some other req set, and lock[o]=0: go to RELEASE; gnt=0; preempt=1 for exactly that one cycle.
  3. Otherwise: stay in GRANT; hold_cnt increments, saturating at MAX_HOLD-1.
- Consequence of rule 2: with competition and no lock, an owner holds gnt for exactly MAX_HOLD cycles.
- A lone requester is never preempted. Its hold_cnt sits saturated, and preemption fires on the first edge at which another req appears (with lock low).
- Lock deasserted while hold_cnt is saturated and others are waiting: release happens on the same edge lock is sampled low.
- State RELEASE: gnt=0 and busy=0 for exactly one dead cycle (bus turnaround). Then apply the IDLE rules; a pending req is granted at the RELEASE-exit edge.
- rr_ptr updates only at a grant edge, so the last owner becomes lowest priority.
- A master that drops req and immediately re-requests still waits behind the other pending masters.
- gnt_idx holds its last value when busy=0.
- preempt is 0 in every other cycle.
- req changes by non-owners while in GRANT have no effect except enabling preemption.
- gnt, gnt_idx, busy and preempt are registered with no combinational path from req or lock.

Test Plan:
1. Reset, then req=0001 → after 1 edge gnt=0001, gnt_idx=0, busy=1; drop req → next edge gnt=0000, busy=0.
2. MAX_HOLD=8, req=1111 held continuously → gnt=0001 for 8 cycles, then 1 dead cycle with preempt=1, then 0010 ×8, dead cycle, 0100 ×8, 1000 ×8, back to 0001.
3. Owner 0 with lock[0]=1, req=0011 held for 20 cycles → gnt stays 0001 and preempt stays 0; deassert lock[0] → gnt=0000 and preempt=1 after the next edge, then gnt=0010.
4. req=0100 held alone for 30 cycles → gnt=0100 throughout, no dead cycles, preempt never 1; raising req[0] then forces release on the next edge.
5. Owner 1 drops req after 3 grant cycles while req[0] and req[3] are pending → 1 dead cycle, then gnt=0100? No: rr_ptr=2, so gnt=1000, and req[0] is granted after 3 releases; check this ordering.
6. Pulse RST_N low mid-grant, between clock edges → gnt=0, busy=0 immediately; after release with req=1010 → gnt=0010 (rr_ptr reset to 0).
